// File: rtl/rc4_pkg.sv
// rc4_pkg: shared RC4 types and sizing constants for the S-memory stages.
package rc4_pkg;

    localparam int S_ADDR_W          = 8;
    localparam int DEFAULT_KEY_BYTES = 3;
    localparam int S_DEPTH           = 1 << S_ADDR_W;

    typedef enum logic [3:0] {
        KSA_IDLE,
        KSA_READ_I,
        KSA_WAIT_I,
        KSA_LATCH_I,
        KSA_READ_J,
        KSA_WAIT_J,
        KSA_LATCH_J,
        KSA_WRITE_I,
        KSA_WRITE_J,
        KSA_NEXT,
        KSA_DONE
    } ksa_state_t;

endpackage

// File: rtl/counter.sv
// counter: N-bit up counter with async active-high reset, sync clear and count enable.
module counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         count_enable,
    output logic [N-1:0] count
);

    logic [N-1:0] count_q, count_d;

    always_comb count_d = clear ? '0 : count_enable ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/ksa_key_byte_select.sv
// ksa_key_byte_select: picks key byte idx from a key word; byte 0 is the most significant byte.
module ksa_key_byte_select #(
    parameter int KEY_BYTES = 3,
    parameter int IDX_W     = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1
) (
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [IDX_W-1:0]       idx,
    output logic [7:0]             key_byte
);

    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++)
            if (idx == IDX_W'(k)) key_byte = key[8*(KEY_BYTES-k)-1 -: 8];
    end

endmodule

// File: rtl/ksa_swap_state_machine.sv
// ksa_swap_state_machine: RC4 key-scheduling swap pass over the shared single-port S RAM.
// Define KSA_SKIP_SELF_SWAP_EN to skip the read/write of s[j] when j lands on i.
module ksa_swap_state_machine
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = DEFAULT_KEY_BYTES,
    parameter int ADDR_W    = S_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [ADDR_W-1:0]      q,
    output logic [ADDR_W-1:0]      address,
    output logic [ADDR_W-1:0]      data,
    output logic                   wren,
    output logic                   done
);

    localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W-1:0] I_LAST = '1;

    ksa_state_t        state_q, state_d;
    logic [ADDR_W-1:0] j_q, j_d, si_q, si_d, sj_q, sj_d, i, j_sum;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W+1:0] j_sum_w;
    logic [7:0]        key_byte;
    logic              i_inc, i_clr;

    counter #(.N(ADDR_W)) u_i_cnt (
        .clk          (clk),
        .reset        (!reset),
        .clear        (i_clr),
        .count_enable (i_inc),
        .count        (i)
    );

    ksa_key_byte_select #(.KEY_BYTES(KEY_BYTES), .IDX_W(KW)) u_key_sel (
        .key      (secret_key),
        .idx      (k_q),
        .key_byte (key_byte)
    );

    // Two guard bits hold the three-term sum before wrapping to the address width.
    assign j_sum_w = (ADDR_W+2)'(j_q) + (ADDR_W+2)'(q) + (ADDR_W+2)'(key_byte);
    assign j_sum   = j_sum_w[ADDR_W-1:0];

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        k_d     = k_q;
        i_inc   = 1'b0;
        i_clr   = 1'b0;
        case (state_q)
            KSA_IDLE:    state_d = start ? KSA_READ_I : KSA_IDLE;
            KSA_READ_I:  state_d = KSA_WAIT_I;
            KSA_WAIT_I:  state_d = KSA_LATCH_I;
            KSA_LATCH_I: begin
                si_d = q;
                j_d  = j_sum;
`ifdef KSA_SKIP_SELF_SWAP_EN
                state_d = (j_sum == i) ? KSA_NEXT : KSA_READ_J;
`else
                state_d = KSA_READ_J;
`endif
            end
            KSA_READ_J:  state_d = KSA_WAIT_J;
            KSA_WAIT_J:  state_d = KSA_LATCH_J;
            KSA_LATCH_J: begin
                sj_d    = q;
                state_d = KSA_WRITE_I;
            end
            KSA_WRITE_I: state_d = KSA_WRITE_J;
            KSA_WRITE_J: state_d = KSA_NEXT;
            KSA_NEXT: begin
                i_inc   = (i != I_LAST);
                k_d     = (i == I_LAST) ? k_q : (k_q == KW'(KEY_BYTES-1)) ? '0 : k_q + 1'b1;
                state_d = (i == I_LAST) ? KSA_DONE : KSA_READ_I;
            end
            KSA_DONE: begin
                i_clr   = !start;
                j_d     = start ? j_q : '0;
                k_d     = start ? k_q : '0;
                state_d = start ? KSA_DONE : KSA_IDLE;
            end
            default:     state_d = KSA_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= KSA_IDLE;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        wren    = (state_q == KSA_WRITE_I) || (state_q == KSA_WRITE_J);
        done    = (state_q == KSA_DONE);
        address = (state_q inside {KSA_READ_I, KSA_WAIT_I, KSA_WRITE_I}) ? i :
                  (state_q inside {KSA_READ_J, KSA_WAIT_J, KSA_WRITE_J}) ? j_q : '0;
        data    = (state_q == KSA_WRITE_I) ? sj_q : (state_q == KSA_WRITE_J) ? si_q : '0;
    end

endmodule

// File: tb/tb_ksa_swap_state_machine.sv
// tb_ksa_swap_state_machine: directed + random-key checks of the KSA swap stage against a software RC4 KSA.
module tb_ksa_swap_state_machine;

`ifdef KSA_SKIP_SELF_SWAP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, init_req = 1'b0;
    logic [23:0] secret_key = '0;
    logic [7:0]  q = '0, a1 = '0, address, data;
    logic        wren, done;
    logic [7:0]  mem [256];
    logic [7:0]  gs [256];
    logic [15:0] glog[$], olog[$];
    int          gself, checks = 0, failures = 0, iter0_len, bad;
    logic [23:0] rkey;

    always #5 clk = ~clk;

    ksa_swap_state_machine #(.KEY_BYTES(3), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .q          (q),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .done       (done)
    );

    // Registered-address RAM with registered output: data appears two cycles after the address.
    always @(posedge clk) begin
        if (init_req) for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        else if (wren) mem[address] <= data;
        a1 <= address;
        q  <= mem[a1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic golden(input logic [23:0] key);
        int j = 0;
        logic [7:0] t;
        glog.delete();
        gself = 0;
        for (int i = 0; i < 256; i++) gs[i] = 8'(i);
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(gs[i]) + int'((key >> (8 * (2 - i % 3))) & 24'hFF)) % 256;
            if (j == i) gself++;
            if (SKIP && j == i) continue;
            glog.push_back({8'(i), gs[j]});
            glog.push_back({8'(j), gs[i]});
            t = gs[i]; gs[i] = gs[j]; gs[j] = t;
        end
    endtask

    task automatic run_ksa(input logic [23:0] key, input int abort_at, output int first1);
        int n = 0;
        bit got = 0;
        secret_key = key;
        golden(key);
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
        olog.delete();
        first1 = -1;
        start = 1'b1;
        @(posedge clk);
        while (n < 5000) begin
            #1;
            if (n == abort_at) break;
            if (wren) olog.push_back({address, data});
            if (address == 8'd1 && first1 < 0) first1 = n;
            if (done) begin got = 1; break; end
            @(posedge clk);
            n++;
        end
        if (n == abort_at) begin
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            #1;
            chk("abort_wren", {31'b0, wren}, 0);
            chk("abort_done", {31'b0, done}, 0);
            chk("abort_addr", {24'b0, address}, 0);
            @(negedge clk) reset = 1'b1;
            return;
        end
        chk("done_reached", {31'b0, got}, 1);
        chk("done_latency", n, SKIP ? 2304 - 5 * gself : 2304);
        chk("wren_count", olog.size(), glog.size());
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== gs[k]) bad++;
        chk("final_s", bad, 0);
        bad = (olog.size() != glog.size()) ? 1 : 0;
        for (int k = 0; k < olog.size() && k < glog.size(); k++) if (olog[k] !== glog[k]) bad++;
        chk("write_log", bad, 0);
        repeat (3) @(posedge clk);
        #1 chk("done_hold", {31'b0, done}, 1);
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_drop", {31'b0, done}, 0);
        chk("idle_addr", {24'b0, address}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", {24'b0, address}, 0);
        chk("rst_data", {24'b0, data}, 0);
        chk("rst_wren", {31'b0, wren}, 0);
        chk("rst_done", {31'b0, done}, 0);
        @(negedge clk) reset = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(posedge clk);
            #1 if (wren || done || address != 8'd0) bad++;
        end
        chk("idle_hold", bad, 0);

        run_ksa(24'h000000, -1, iter0_len);
        chk("iter0_len", iter0_len, SKIP ? 4 : 9);

        run_ksa(24'h123456, -1, iter0_len);
        while (olog.size() < 2) olog.push_back(16'hxxxx);
        chk("key123456_w0", {16'b0, olog[0]}, 32'h0012);
        chk("key123456_w1", {16'b0, olog[1]}, 32'h1200);

        run_ksa(24'hFFFFFF, -1, iter0_len);

        rkey = 24'($urandom);
        run_ksa(rkey, 100 * 9 + 3, iter0_len);
        run_ksa(rkey, -1, iter0_len);

        repeat (2) run_ksa(24'($urandom), -1, iter0_len);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
